// File: rtl/ifu_pkg.sv
// Shared types for the instruction fetch unit: FSM states, buffer entry layout and PC constants.
// No logic lives here.
package ifu_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      WAIT    = 2'd2,
      DISCARD = 2'd3
   } ifu_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ifu_entry_t;

   localparam logic [31:0] PC_INC        = 32'd4;
   localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/ifu_buffer.sv
// Parameterised-depth instruction FIFO with flush; head is registered (push visible next cycle).
// Push is accepted when not full or when popping in the same cycle; flush empties it at once.
module ifu_buffer
   import ifu_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic                         clk,
   input  logic                         system_reset_n,
   input  logic                         flush,
   input  logic                         push,
   input  ifu_entry_t                   push_entry,
   input  logic                         pop,
   output ifu_entry_t                   head,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SLOTS = 2 ** AW;
   localparam int CW    = $clog2(DEPTH + 1);

   ifu_entry_t    mem [SLOTS];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (!system_reset_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding IMEM request feeding a buffer of depth 1 (2 with IFU_PREFETCH_EN).
// Fetches stall while buffer plus in-flight request would exceed depth; taken branches flush and redirect.
module instr_fetch_unit
   import ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        system_reset_n,
   input  logic        E_PC,
   input  logic        select_programcounter,
   input  logic        branch_cmp_output,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst_CCD,
   output logic        inst_valid,
   output logic [31:0] inst_pc
);

`ifdef IFU_PREFETCH_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   ifu_state_t                    state;
   ifu_state_t                    state_nxt;
   logic [31:0]                   fetch_pc;
   logic [31:0]                   req_pc;
   logic                          redirect;
   logic                          pop;
   logic                          push;
   logic                          slot_after_push;
   logic                          buf_full;
   logic                          buf_empty;
   logic [$clog2(DEPTH+1)-1:0]    count;
   ifu_entry_t                    head;
   ifu_entry_t                    push_entry;

   assign pop             = E_PC && inst_valid;
   assign redirect        = pop && select_programcounter && branch_cmp_output;
   assign slot_after_push = pop || (int'(count) < DEPTH - 1);
   assign push_entry      = '{pc: req_pc, inst: imem_rdata};

   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      case (state)
         IDLE:    if (!buf_full || pop) state_nxt = REQ;
         REQ:     if (imem_ack) state_nxt = WAIT;
         WAIT: begin
            if (imem_rvalid) begin
               push      = 1'b1;
               state_nxt = slot_after_push ? REQ : IDLE;
            end
         end
         DISCARD: if (imem_rvalid) state_nxt = REQ;
         default: state_nxt = IDLE;
      endcase
      // A beat arriving in the redirect cycle is dropped here, so nothing is left to discard.
      if (redirect) begin
         push = 1'b0;
         case (state)
            WAIT, DISCARD: state_nxt = imem_rvalid ? REQ : DISCARD;
            REQ:           state_nxt = imem_ack ? DISCARD : REQ;
            default:       state_nxt = REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!system_reset_n) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         req_pc   <= RESET_PC;
      end else begin
         state <= state_nxt;
         if (redirect) begin
            fetch_pc <= branch_target & PC_ALIGN_MASK;
         end else if (state == REQ && imem_ack) begin
            fetch_pc <= fetch_pc + PC_INC;
         end
         if (state == REQ && imem_ack) begin
            req_pc <= fetch_pc;
         end
      end
   end

   ifu_buffer #(.DEPTH(DEPTH)) u_buffer (
      .clk            (clk),
      .system_reset_n (system_reset_n),
      .flush          (redirect),
      .push           (push),
      .push_entry     (push_entry),
      .pop            (pop && !redirect),
      .head           (head),
      .full           (buf_full),
      .empty          (buf_empty),
      .count          (count)
   );

   assign imem_req   = (state == REQ);
   assign imem_addr  = fetch_pc;
   assign inst_valid = !buf_empty;
   assign inst_CCD   = buf_empty ? NOP_INST : head.inst;
   assign inst_pc    = buf_empty ? 32'h0 : head.pc;

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013: value of inst_CCD while no instruction is valid.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-004 SHALL have port system_reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port E_PC  input  1  decoder consumes the current instruction this cycle.
REQ-006 SHALL have port select_programcounter  input  1  current instruction is a branch.
REQ-007 SHALL have port branch_cmp_output  input  1  branch taken.
REQ-008 SHALL have port branch_target  input  32  redirect address.
REQ-009 SHALL have port imem_req  output  1  fetch request to IMEM.
REQ-010 SHALL have port imem_addr  output  32  fetch address, word-aligned.
REQ-011 SHALL have port imem_ack  input  1  IMEM accepts the request this cycle.
REQ-012 SHALL have port imem_rvalid  input  1  read data valid.
REQ-013 SHALL have port imem_rdata  input  32  instruction word.
REQ-014 SHALL have port inst_CCD  output  32  instruction to the control generator.
REQ-015 SHALL have port inst_valid  output  1  inst_CCD holds a real instruction.
REQ-016 SHALL have port inst_pc  output  32  address of inst_CCD.

Function
REQ-017 SHALL hold fetch_pc, issue address, incremented by 4 on each imem_ack, wrapping 32'hFFFF_FFFC -> 32'h0.
REQ-018 SHALL use FSM states IDLE, REQ, WAIT and DISCARD.
REQ-019 In IDLE, SHALL go to REQ when the buffer has a free slot; imem_req=0.
REQ-020 In REQ, SHALL drive imem_req=1 with imem_addr=fetch_pc; imem_req and imem_addr SHALL stay stable until imem_ack; on imem_ack SHALL go to WAIT.
REQ-021 In WAIT, on imem_rvalid SHALL push {fetch address, imem_rdata} into the buffer, then go to REQ if a slot remains, else IDLE.
REQ-022 In DISCARD, SHALL drop the next imem_rvalid beat and then go to REQ.
REQ-023 At most one request SHALL be outstanding; requests SHALL only issue while buffered entries plus outstanding requests are below buffer depth.
REQ-024 imem_rvalid outside WAIT/DISCARD SHALL be ignored.
REQ-025 inst_valid SHALL equal buffer non-empty; inst_CCD/inst_pc SHALL show the head entry, else NOP_INST/32'h0.
REQ-026 E_PC with inst_valid=1 SHALL pop the head; E_PC with inst_valid=0 SHALL have no effect.
REQ-027 Redirect = E_PC & inst_valid & select_programcounter & branch_cmp_output; it SHALL flush the buffer and load fetch_pc with {branch_target[31:2],2'b00} in the same cycle.
REQ-028 On redirect, SHALL go to DISCARD from WAIT, to REQ from REQ/IDLE, drop the imem_req it was holding, and drop any imem_rvalid in the same cycle.
REQ-029 imem_ack in the redirect cycle SHALL count as accepted, and its response SHALL be discarded.
REQ-030 Push and pop in the same cycle SHALL be allowed when full; occupancy stays unchanged.
REQ-031 First inst_valid after reset SHALL occur one cycle after the first imem_rvalid (registered buffer).

Reset
REQ-032 While system_reset_n=0 at posedge: FSM=IDLE, fetch_pc=RESET_PC, buffer empty, imem_req=0, inst_valid=0, inst_CCD=NOP_INST, inst_pc=0.
REQ-033 Reset during WAIT SHALL drop the outstanding request; a later imem_rvalid SHALL be ignored.

Configuration
REQ-034 With IFU_PREFETCH_EN defined, buffer depth SHALL be 2.
REQ-035 Without IFU_PREFETCH_EN, depth SHALL be 1: no new request until the held instruction is popped.

Structure
REQ-036 Package ifu_pkg SHALL hold the FSM state enum, the buffer entry struct {pc, inst}, and the PC increment constant (4).
REQ-037 Sub-module ifu_buffer SHALL implement the parameterised-depth FIFO with flush, push, pop, full and empty.

Verification
REQ-038 Reset then IMEM ack+rvalid with 1-cycle latency, E_PC held 1 -> imem_addr 0x0, 0x4, 0x8, and inst_pc follows in order.
REQ-039 imem_ack withheld 5 cycles -> imem_req and imem_addr=0x4 stable throughout.
REQ-040 Taken branch to 0x103 while a request is in WAIT -> stale beat dropped, next imem_addr=0x100, and first inst_pc after the redirect is 0x100.
REQ-041 E_PC=0 with depth 2 -> exactly two requests, then imem_req=0; one pop -> one new request.
REQ-042 Reset asserted in WAIT, then rvalid -> inst_valid stays 0 and imem_addr=RESET_PC.
REQ-043 fetch_pc=0xFFFF_FFFC acked -> next imem_addr=0x0.
